spi_responder: RTL



---
 rtl/spi_pkg.sv | 18 +
 rtl/spi_sync_edge.sv | 33 +++
 rtl/spi_responder.sv | 128 ++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: responder state encoding, result width and the
// clock-mode helper also used by the SPI master.
package spi_pkg;

    typedef enum logic [1:0] {
        WAIT_IDLE,
        IDLE,
        ACTIVE
    } spi_state_t;

    localparam int SPI_RESULT_WIDTH = 32;

    // Data is valid on the rising spi_clk edge when pol and pha agree.
    function automatic logic spi_sample_on_rise(input logic pol, input logic pha);
        return ~(pol ^ pha);
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer for one asynchronous input, with rise/fall detect
// against a registered copy of the synchronized level.
module spi_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic i_d,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // Resetting to 0 means a chip select held low through reset never looks
    // like a fresh falling edge, so an interrupted frame cannot restart.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;
    assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/spi_responder.sv
// SPI peripheral endpoint: oversamples cs/clk/mosi in the system clock domain,
// shifts in the command word and shifts out a preloaded response on MISO.
module spi_responder
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH  = SPI_RESULT_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          spi_cs,
    input  logic                          spi_clk,
    input  logic                          spi_mosi,
    output logic                          spi_miso,
    output logic                          spi_miso_oe,
    input  logic                          clk_pol,
    input  logic                          clk_pha,
    input  logic [DATA_WIDTH-1:0]         tx_data,
    input  logic                          tx_write,
    output logic                          tx_pending,
    output logic [DATA_WIDTH-1:0]         rx_data,
    output logic [$clog2(DATA_WIDTH):0]   rx_nbits,
    output logic                          rx_valid,
    output logic                          rx_overflow,
    output logic                          busy
);

    localparam int NW = $clog2(DATA_WIDTH) + 1;

    logic w_cs_lvl, w_cs_rise, w_cs_fall;
    logic w_clk_lvl, w_clk_rise, w_clk_fall;
    logic w_mosi_lvl, w_unused_mosi_rise, w_unused_mosi_fall;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_cs (
        .clock(clock), .reset(reset), .i_d(spi_cs),
        .o_level(w_cs_lvl), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
    );
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_clk (
        .clock(clock), .reset(reset), .i_d(spi_clk),
        .o_level(w_clk_lvl), .o_rise(w_clk_rise), .o_fall(w_clk_fall)
    );
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_mosi (
        .clock(clock), .reset(reset), .i_d(spi_mosi),
        .o_level(w_mosi_lvl), .o_rise(w_unused_mosi_rise), .o_fall(w_unused_mosi_fall)
    );

    spi_state_t              r_state, w_next;
    logic                    r_sample_rise;
    logic [DATA_WIDTH-1:0]   r_pending;
    logic                    r_pending_full;
    logic [DATA_WIDTH-1:0]   r_tx_shift;
    logic [DATA_WIDTH-1:0]   r_rx_data;
    logic [NW-1:0]           r_nbits;
    logic                    r_overflow;
    logic                    r_rx_valid;

    logic w_start, w_sample_edge, w_shift_edge;
    logic w_unused_clk_lvl;

    assign w_unused_clk_lvl = w_clk_lvl;
    assign w_start       = (r_state == IDLE) && w_cs_fall;
    assign w_sample_edge = r_sample_rise ? w_clk_rise : w_clk_fall;
    assign w_shift_edge  = r_sample_rise ? w_clk_fall : w_clk_rise;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= WAIT_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            WAIT_IDLE: if (w_cs_lvl)  w_next = IDLE;
            IDLE:      if (w_cs_fall) w_next = ACTIVE;
            ACTIVE:    if (w_cs_rise) w_next = IDLE;
            default:   w_next = WAIT_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sample_rise  <= 1'b0;
            r_pending      <= '0;
            r_pending_full <= 1'b0;
            r_tx_shift     <= '0;
            r_rx_data      <= '0;
            r_nbits        <= '0;
            r_overflow     <= 1'b0;
            r_rx_valid     <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            if (tx_write) begin
                r_pending      <= tx_data;
                r_pending_full <= 1'b1;
            end
            if (w_start) begin
                r_sample_rise  <= spi_sample_on_rise(clk_pol, clk_pha);
                // A write landing on the select cycle goes straight to the wire.
                r_tx_shift     <= tx_write ? tx_data : (r_pending_full ? r_pending : '0);
                r_pending_full <= 1'b0;
                r_rx_data      <= '0;
                r_nbits        <= '0;
                r_overflow     <= 1'b0;
            end else if (r_state == ACTIVE) begin
                if (w_cs_rise) begin
                    r_rx_valid <= (r_nbits != '0);
                end else if (w_sample_edge) begin
                    r_rx_data <= {r_rx_data[DATA_WIDTH-2:0], w_mosi_lvl};
                    if (r_nbits == NW'(DATA_WIDTH)) r_overflow <= 1'b1;
                    else                            r_nbits    <= r_nbits + 1'b1;
                end else if (w_shift_edge && (r_nbits != '0)) begin
                    // No shift before the first sample keeps the MSB up for CPHA=1.
                    r_tx_shift <= {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
                end
            end
        end
    end

    assign busy        = (r_state == ACTIVE);
    assign spi_miso_oe = busy;
    assign spi_miso    = busy & r_tx_shift[DATA_WIDTH-1];
    assign tx_pending  = r_pending_full;
    assign rx_data     = r_rx_data;
    assign rx_nbits    = r_nbits;
    assign rx_valid    = r_rx_valid;
    assign rx_overflow = r_overflow;

endmodule
